// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the architectural PC and keeps at most one instruction-memory request
// outstanding. Branch/jump redirects squash stale fetches. A one-entry buffer
// toward decode holds its instruction while decode stalls.
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When it is defined, a
// redirect target is forced to word alignment and o_misalign pulses for one
// cycle after a misaligned target is seen.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic [31:0] o_inst_pc_plus4,
    output logic        o_misalign
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] inst_pc4_q, inst_pc4_d;
    logic        misalign_q, misalign_d;

    logic        consumed_s;
    logic        free_s;
    logic        req_s;
    logic        accept_s;
    logic        buf_wr_s;
    logic        target_misaligned_s;
    logic [31:0] target_s;

    // Handshake qualifiers: buffer occupancy and whether a request is taken.
    always_comb begin
        consumed_s = inst_valid_q & ~i_stall;
        free_s     = ~inst_valid_q | consumed_s;
        req_s      = (state_q == ST_REQ) & free_s;
        accept_s   = req_s & i_imem_gnt;
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // Redirect target is forced onto a word boundary; low bits are reported.
    always_comb begin
        target_misaligned_s = (i_redirect_pc[1:0] != 2'b00);
        target_s            = i_redirect_pc & ~32'h0000_0003;
    end
`else
    // Redirect target is taken verbatim and never reported as misaligned.
    always_comb begin
        target_misaligned_s = 1'b0;
        target_s            = i_redirect_pc;
    end
`endif

    // Fetch sequencing: next state, next PC and buffer-write decision.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_wr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (i_redirect) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_REQ: begin
                if (i_redirect) begin
                    // A granted request must have its response dropped.
                    pc_d    = target_s;
                    state_d = accept_s ? ST_FLUSH : ST_REQ;
                end else if (accept_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_redirect) begin
                    // Response arriving with the redirect is already stale.
                    pc_d    = target_s;
                    state_d = i_imem_rvalid ? ST_REQ : ST_FLUSH;
                end else if (i_imem_rvalid) begin
                    buf_wr_s = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    state_d  = ST_REQ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                if (i_redirect) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                state_d = i_imem_rvalid ? ST_REQ : ST_FLUSH;
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = pc_q;
            end
        endcase
    end

    // Instruction buffer: redirect squashes, fresh write beats consumption.
    always_comb begin
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_pc4_d   = inst_pc4_q;
        if (i_redirect) begin
            inst_valid_d = 1'b0;
        end else if (buf_wr_s) begin
            inst_valid_d = 1'b1;
            inst_d       = i_imem_rdata;
            inst_pc_d    = pc_q;
            inst_pc4_d   = pc_q + 32'd4;
        end else if (consumed_s) begin
            inst_valid_d = 1'b0;
        end else begin
            inst_valid_d = inst_valid_q;
        end
        misalign_d = i_redirect & target_misaligned_s;
    end

    // State, PC and buffer registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= 32'h0000_0000;
            inst_pc4_q   <= 32'h0000_0004;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_pc4_q   <= inst_pc4_d;
            misalign_q   <= misalign_d;
        end
    end

    assign o_imem_req      = req_s;
    assign o_imem_addr     = pc_q;
    assign o_inst_valid    = inst_valid_q;
    assign o_inst          = inst_q;
    assign o_inst_pc       = inst_pc_q;
    assign o_inst_pc_plus4 = inst_pc4_q;
    assign o_misalign      = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: randomized memory/stall/redirect stimulus with a
// stream-level reference model. Delivered instructions must follow the
// sequential stream from the latest redirect target (or RESET_PC).
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        i_stall = 1'b0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic [31:0] o_inst_pc_plus4;
    logic        o_misalign;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_gnt     (i_imem_gnt),
        .i_imem_rvalid  (i_imem_rvalid),
        .i_imem_rdata   (i_imem_rdata),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .i_stall        (i_stall),
        .o_inst_valid   (o_inst_valid),
        .o_inst         (o_inst),
        .o_inst_pc      (o_inst_pc),
        .o_inst_pc_plus4(o_inst_pc_plus4),
        .o_misalign     (o_misalign)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    int consumes = 0;

    // Scoreboard of expected delivered instructions
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] stream_pc;

    // Memory model state
    bit          outstanding = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    bit          pend_redir = 1'b0;
    logic [31:0] pend_target = 32'h0;
    logic [31:0] targets[6];

    // Monitor state
    bit          mon_prev_redir = 1'b0;
    logic [31:0] mon_prev_t = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    function automatic logic exp_mis(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
        return (t[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_req", {31'b0, o_imem_req}, 32'd0);
        check("rst_addr", o_imem_addr, RESET_PC);
        check("rst_valid", {31'b0, o_inst_valid}, 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_inst_pc", o_inst_pc, 32'd0);
        check("rst_pc4", o_inst_pc_plus4, 32'd4);
        check("rst_misalign", {31'b0, o_misalign}, 32'd0);
    endtask

    task automatic model_reset();
        exp_pc_q.delete();
        exp_inst_q.delete();
        stream_pc   = RESET_PC;
        outstanding = 1'b0;
        lat_cnt     = 0;
        pend_redir  = 1'b0;
    endtask

    // One clock of stimulus: memory response, stall, grant, redirect.
    // force_redir: 0 none, 1 always, 2 only together with a response.
    task automatic drive(input bit ideal, input bit allow_redir, input bit force_stall,
                         input int force_redir, input logic [31:0] force_t,
                         output bit redirected);
        bit busy;
        @(posedge i_clk);
        #1;
        if (pend_redir) begin
            exp_pc_q.delete();
            exp_inst_q.delete();
            stream_pc  = eff_target(pend_target);
            pend_redir = 1'b0;
        end
        while (exp_pc_q.size() < 4) begin
            exp_pc_q.push_back(stream_pc);
            exp_inst_q.push_back(mem_word(stream_pc));
            stream_pc = stream_pc + 32'd4;
        end
        busy = outstanding;
        if (outstanding && lat_cnt == 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(mem_addr);
            outstanding   = 1'b0;
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
            if (outstanding) lat_cnt = lat_cnt - 1;
        end
        i_stall    = force_stall || (!ideal && $urandom_range(0, 3) == 0);
        i_imem_gnt = ideal || ($urandom_range(0, 2) != 0);
        targets[5] = $urandom & 32'hFFFF_FFFC;
        redirected = (force_redir == 1) || (force_redir == 2 && i_imem_rvalid) ||
                     (allow_redir && $urandom_range(0, 9) == 0);
        i_redirect    = redirected;
        i_redirect_pc = (force_redir != 0) ? force_t : targets[$urandom_range(0, 5)];
        #1;
        if (busy) check("req_single_outstanding", {31'b0, o_imem_req}, 32'd0);
        if (o_imem_req && i_imem_gnt) begin
            outstanding = 1'b1;
            mem_addr    = o_imem_addr;
            lat_cnt     = ideal ? 0 : $urandom_range(0, 3);
        end
        pend_redir  = i_redirect;
        pend_target = i_redirect_pc;
    endtask

    // Monitor: compares delivered instructions and per-cycle flags.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                if (mon_prev_redir) check("redir_addr", o_imem_addr, eff_target(mon_prev_t));
                check("misalign", {31'b0, o_misalign},
                      {31'b0, mon_prev_redir && exp_mis(mon_prev_t)});
                if (o_inst_valid && i_stall) check("req_in_stall", {31'b0, o_imem_req}, 32'd0);
                if (o_inst_valid && !i_stall) begin
                    consumes++;
                    if (exp_pc_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: got inst pc %h expected none", o_inst_pc);
                    end else begin
                        logic [31:0] epc;
                        logic [31:0] einst;
                        epc   = exp_pc_q.pop_front();
                        einst = exp_inst_q.pop_front();
                        check("inst_pc", o_inst_pc, epc);
                        check("inst", o_inst, einst);
                        check("inst_pc4", o_inst_pc_plus4, epc + 32'd4);
                    end
                end
                mon_prev_redir = i_redirect;
                mon_prev_t     = i_redirect_pc;
            end else begin
                mon_prev_redir = 1'b0;
            end
        end
    end

    // Stimulus sequence
    initial begin
        bit did;
        int c0;
        targets[0] = 32'h0000_0100;
        targets[1] = 32'h0000_0200;
        targets[2] = 32'h0000_0300;
        targets[3] = 32'hFFFF_FFF8;
        targets[4] = 32'h0000_0102;
        targets[5] = 32'h0000_0400;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_values();
        i_rst = 1'b1;

        // Ideal memory, no stall: one instruction every two cycles
        repeat (10) drive(1'b1, 1'b0, 1'b0, 0, 32'h0, did);
        c0 = consumes;
        repeat (40) drive(1'b1, 1'b0, 1'b0, 0, 32'h0, did);
        check("throughput", consumes - c0, 32'd20);

        // Long stall with a valid buffer, then release
        repeat (8) drive(1'b1, 1'b0, 1'b1, 0, 32'h0, did);
        repeat (6) drive(1'b1, 1'b0, 1'b0, 0, 32'h0, did);

        // Redirect coinciding with a response
        did = 1'b0;
        for (int i = 0; i < 6 && !did; i++) drive(1'b1, 1'b0, 1'b0, 2, 32'h0000_0100, did);
        repeat (8) drive(1'b1, 1'b0, 1'b0, 0, 32'h0, did);

        // PC wrap-around
        drive(1'b1, 1'b0, 1'b0, 1, 32'hFFFF_FFFC, did);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 0, 32'h0, did);

        // Misaligned redirect target
        drive(1'b1, 1'b0, 1'b0, 1, 32'h0000_0102, did);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 0, 32'h0, did);

        // Random traffic
        repeat (3000) drive(1'b0, 1'b1, 1'b0, 0, 32'h0, did);

        // Reset in the middle of traffic
        drive(1'b0, 1'b0, 1'b0, 0, 32'h0, did);
        @(posedge i_clk);
        #1;
        i_rst         = 1'b0;
        i_redirect    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_gnt    = 1'b0;
        i_stall       = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        repeat (300) drive(1'b0, 1'b1, 1'b0, 0, 32'h0, did);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 0, 32'h0, did);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
